m24_bus_arbiter: RTL
====================

// Module: m24_bus_arbiter
// PURPOSE
//  Shares the single M24C08 I2C bus between two masters: requester 0 (EEPROM reader, boot readout)
//  and requester 1 (EEPROM writer, AT93C46 write-back). Grants exclusive bus ownership, muxes the
//  owner's open-drain SCL/SDA/SDAT lines to the pads, enforces bus-free time between owners, and
//  aborts a hung owner by watchdog. Replaces wired-AND merging of reader/writer lines in the top.
// PARAMETERS
//  BUS_FREE_TICKS  4'd2       PULSE5uS_IN ticks the bus stays released between grants (>=1)
//  TIMEOUT_TICKS   16'd20000  PULSE5uS_IN ticks a grant may last before abort (100 ms)
// PORTS
//  SYSCLK_IN        in   1  system clock
//  RESET_IN         in   1  synchronous, active-high reset
//  PULSE5uS_IN      in   1  1-cycle tick every 5 us
//  REQ0_IN/REQ1_IN  in   1  level request; held for the whole transaction
//  GNT0_OUT/GNT1_OUT out 1  registered grant
//  SCLn_IN,SDAn_IN  in   1  requester n lines, 0=pull low, 1=release (n=0,1)
//  SDATn_IN         in   1  requester n SDA tristate, 0=drive, 1=release
//  M24C08_SCL_OUT   out  1  pad SCL (0=pull low)
//  M24C08_SDA_OUT   out  1  pad SDA
//  M24C08_SDAT_OUT  out  1  pad SDA drive enable, 1=drive
//  BUSY_OUT         out  1  1 in GRANT or RELEASE state
//  TIMEOUT_OUT      out  1  1-cycle pulse on watchdog abort
// BEHAVIOUR
//  - Reset values: GNT0/1=0, SCL=1, SDA=1, SDAT_OUT=0, BUSY=0, TIMEOUT=0, state IDLE, LAST=1.
//  - States: IDLE -> GRANT -> RELEASE -> IDLE. All outputs registered.
//  - IDLE: an eligible REQ registers GNTn=1 on next edge (1-cycle latency), go GRANT.
//    Both eligible: grant the requester != LAST (round-robin); LAST=1 at reset so REQ0 wins first.
//    LAST updates to n at grant.
//  - GRANT: pads = owner's inputs (SCL=SCLn, SDA=SDAn, SDAT_OUT=~SDATn), registered, 1-cycle delay;
//    non-owner inputs ignored entirely. REQn low -> GNTn=0 and pads released on next edge, go RELEASE.
//  - RELEASE: pads released (1,1,0); count PULSE5uS_IN; after BUS_FREE_TICKS pulses -> IDLE.
//    Requests arriving meanwhile wait; no grant while in RELEASE.
//  - Eligibility: requester n is ineligible after an abort until REQn seen low >=1 cycle.
//  - Tick counters 16 bit, cleared on every state entry; no wrap (compare ==, stop at terminal).
//  - Reset mid-transaction: next edge returns reset values; pads released immediately; no stop bit.
//  - Grant and request-drop same cycle as tick: state transition takes precedence, counter clears.
// CONFIGURATION
//  M24_ARB_WATCHDOG_EN defined: in GRANT, count PULSE5uS_IN; at TIMEOUT_TICKS -> GNTn=0, pads
//    released, TIMEOUT_OUT=1 for one cycle, owner ineligible, go RELEASE.
//  Undefined: no watchdog logic; TIMEOUT_OUT tied 0; grant lasts until REQn drops.
// TESTING
//  1 REQ0=1 only -> GNT0=1 one cycle later; SCL0_IN=0 -> pad SCL=0 next cycle; SCL1_IN=0 no effect.
//  2 After reset REQ0=REQ1=1 same cycle -> GNT0; drop REQ0 -> 2 ticks later GNT1; re-raise both
//    after release -> GNT0 (round-robin).
//  3 Drop REQ1 while REQ0 pending -> GNT1=0 next edge, BUSY=1, GNT0 asserted only after 2nd tick.
//  4 WATCHDOG_EN, TIMEOUT_TICKS=4, REQ0 held -> at 4th tick GNT0=0, TIMEOUT_OUT 1-cycle pulse,
//    pads 1/1/0; REQ0 still high -> never re-granted; REQ0 low 1 cycle then high -> granted.
//  5 RESET_IN=1 during GRANT with SDA0_IN=0 -> next edge GNT0=0, SDA=1, SDAT_OUT=0, BUSY=0.
//  6 Macro undefined, REQ1 held 50000 ticks -> GNT1 stays 1, TIMEOUT_OUT stays 0.

Source files
------------

// File: rtl/m24_bus_arbiter.sv
// Two-master arbiter for the shared M24C08 I2C bus: round-robin grant, owner line mux, bus-free gap.
// Optional watchdog abort of a hung owner is built only when M24_ARB_WATCHDOG_EN is defined.
module m24_bus_arbiter #(
    parameter logic [3:0]  BUS_FREE_TICKS = 4'd2,
    parameter logic [15:0] TIMEOUT_TICKS  = 16'd20000
) (
    input  logic SYSCLK_IN,
    input  logic RESET_IN,
    input  logic PULSE5uS_IN,
    input  logic REQ0_IN,
    input  logic REQ1_IN,
    output logic GNT0_OUT,
    output logic GNT1_OUT,
    input  logic SCL0_IN,
    input  logic SDA0_IN,
    input  logic SDAT0_IN,
    input  logic SCL1_IN,
    input  logic SDA1_IN,
    input  logic SDAT1_IN,
    output logic M24C08_SCL_OUT,
    output logic M24C08_SDA_OUT,
    output logic M24C08_SDAT_OUT,
    output logic BUSY_OUT,
    output logic TIMEOUT_OUT
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    localparam logic [15:0] FREE_TERM = {12'd0, BUS_FREE_TICKS};
    // The single tick counter never needs to run past the larger of the two terminals.
    localparam logic [15:0] CNT_TERM  = (TIMEOUT_TICKS > FREE_TERM) ? TIMEOUT_TICKS : FREE_TERM;

    logic [1:0]  state;
    logic [15:0] tick_cnt;
    logic [15:0] cnt_next;
    logic        last;
    logic        elig0, elig1;
    logic        want0, want1, pick1;
    logic        req_own, scl_own, sda_own, sdat_own;
    logic        gnt0, gnt1, scl, sda, sdat, busy, tout;

    function automatic logic [15:0] tick_inc(input logic [15:0] c);
        return (c == CNT_TERM) ? c : c + 16'd1;
    endfunction

    always_comb begin
        want0    = REQ0_IN && elig0;
        want1    = REQ1_IN && elig1;
        // With both eligible, the requester that did not own the bus last time wins.
        pick1    = want1 && (!want0 || !last);
        req_own  = last ? REQ1_IN  : REQ0_IN;
        scl_own  = last ? SCL1_IN  : SCL0_IN;
        sda_own  = last ? SDA1_IN  : SDA0_IN;
        sdat_own = last ? SDAT1_IN : SDAT0_IN;
        cnt_next = tick_inc(tick_cnt);
    end

    always_ff @(posedge SYSCLK_IN) begin
        if (RESET_IN) begin
            state    <= S_IDLE;
            tick_cnt <= 16'd0;
            last     <= 1'b1;
            elig0    <= 1'b1;
            elig1    <= 1'b1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            scl      <= 1'b1;
            sda      <= 1'b1;
            sdat     <= 1'b0;
            busy     <= 1'b0;
            tout     <= 1'b0;
        end else begin
            tout <= 1'b0;
            if (!REQ0_IN) elig0 <= 1'b1;
            if (!REQ1_IN) elig1 <= 1'b1;
            case (state)
                S_IDLE: begin
                    scl  <= 1'b1;
                    sda  <= 1'b1;
                    sdat <= 1'b0;
                    if (want0 || want1) begin
                        state    <= S_GRANT;
                        tick_cnt <= 16'd0;
                        last     <= pick1;
                        gnt0     <= !pick1;
                        gnt1     <= pick1;
                        busy     <= 1'b1;
                    end
                end
                S_GRANT: begin
                    if (!req_own) begin
                        state    <= S_RELEASE;
                        tick_cnt <= 16'd0;
                        gnt0     <= 1'b0;
                        gnt1     <= 1'b0;
                        scl      <= 1'b1;
                        sda      <= 1'b1;
                        sdat     <= 1'b0;
                    end
`ifdef M24_ARB_WATCHDOG_EN
                    else if (PULSE5uS_IN && cnt_next == TIMEOUT_TICKS) begin
                        state    <= S_RELEASE;
                        tick_cnt <= 16'd0;
                        gnt0     <= 1'b0;
                        gnt1     <= 1'b0;
                        scl      <= 1'b1;
                        sda      <= 1'b1;
                        sdat     <= 1'b0;
                        tout     <= 1'b1;
                        if (last) elig1 <= 1'b0;
                        else      elig0 <= 1'b0;
                    end
`endif
                    else begin
                        scl  <= scl_own;
                        sda  <= sda_own;
                        sdat <= ~sdat_own;
`ifdef M24_ARB_WATCHDOG_EN
                        if (PULSE5uS_IN) tick_cnt <= cnt_next;
`endif
                    end
                end
                S_RELEASE: begin
                    scl  <= 1'b1;
                    sda  <= 1'b1;
                    sdat <= 1'b0;
                    if (PULSE5uS_IN) begin
                        if (cnt_next == FREE_TERM) begin
                            state    <= S_IDLE;
                            tick_cnt <= 16'd0;
                            busy     <= 1'b0;
                        end else begin
                            tick_cnt <= cnt_next;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    tick_cnt <= 16'd0;
                    gnt0     <= 1'b0;
                    gnt1     <= 1'b0;
                    scl      <= 1'b1;
                    sda      <= 1'b1;
                    sdat     <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    assign GNT0_OUT        = gnt0;
    assign GNT1_OUT        = gnt1;
    assign M24C08_SCL_OUT  = scl;
    assign M24C08_SDA_OUT  = sda;
    assign M24C08_SDAT_OUT = sdat;
    assign BUSY_OUT        = busy;
    assign TIMEOUT_OUT     = tout;

endmodule
